// File: rtl/iru_pkg.sv
// iru_pkg: shared geometry constants, state encoding and the row-select helper
// used by the IRU receive block (iru_rx) and its min/max reduction sub-module.
package iru_pkg;

  localparam int IMG_DIM     = 20;
  localparam int GROUPS      = 5;
  localparam int GROUP_BYTES = 80;
  localparam int ROW_IDX_W   = 5;

  localparam logic [ROW_IDX_W-1:0] LAST_ROW = 5'd19;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } iru_state_e;

  typedef logic [IMG_DIM-1:0][7:0]                   row_t;
  typedef logic [GROUPS-1:0][GROUP_BYTES-1:0][7:0]   block_t;

  // Row r lives in group r/4 starting at byte (r%4)*20: four rows fill one 80-byte group.
  function automatic row_t row_select(input block_t blk, input logic [ROW_IDX_W-1:0] idx);
    row_t       row;
    logic [2:0] grp;
    logic [6:0] base;
    grp  = idx[4:2];
    base = {5'd0, idx[1:0]} * 7'd20;
    for (int c = 0; c < IMG_DIM; c++) begin
      row[c] = blk[grp][base + 7'(c)];
    end
    return row;
  endfunction

endpackage

// File: rtl/iru_rx_minmax.sv
// iru_rx_minmax: purely combinational minimum/maximum over one 20-pixel row.
// Only instantiated when IRU_RX_MINMAX_EN is defined.
module iru_rx_minmax
  import iru_pkg::*;
(
  input  logic [IMG_DIM-1:0][7:0] i_row,
  output logic [7:0]              o_min,
  output logic [7:0]              o_max
);

  // Linear fold across the row; start from the identity values of min and max.
  always_comb begin
    o_min = 8'hFF;
    o_max = 8'h00;
    for (int c = 0; c < IMG_DIM; c++) begin
      o_min = (i_row[c] < o_min) ? i_row[c] : o_min;
      o_max = (i_row[c] > o_max) ? i_row[c] : o_max;
    end
  end

endmodule

// File: rtl/iru_rx.sv
// iru_rx: captures a rotated 20x20 byte block from the IRU and streams it out
// one row per accepted transfer (valid/ready), then frees the buffer.
// Optional feature macro: IRU_RX_MINMAX_EN adds per-block pixel min/max
// statistics with a stat_valid pulse; without it those outputs are tied to 0.
module iru_rx
  import iru_pkg::*;
(
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     iru_out_ready,
  input  logic [GROUPS-1:0][GROUP_BYTES-1:0][7:0]  iru_q,
  output logic                                     rx_ready,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [IMG_DIM-1:0][7:0]                  out_row,
  output logic [ROW_IDX_W-1:0]                     out_row_idx,
  output logic                                     out_last,
  output logic [7:0]                               img_min,
  output logic [7:0]                               img_max,
  output logic                                     stat_valid
);

  iru_state_e           r_state;
  iru_state_e           w_next_state;
  block_t               r_blk;
  row_t                 r_row;
  logic [ROW_IDX_W-1:0] r_row_idx;
  logic                 r_last;
  logic                 w_capture;
  logic                 w_xfer;
  logic                 w_xfer_last;

  // State register; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and strobe decode: capture in IDLE, row transfers in STREAM.
  always_comb begin
    w_next_state = r_state;
    w_capture    = 1'b0;
    w_xfer       = 1'b0;
    w_xfer_last  = 1'b0;
    case (r_state)
      IDLE: begin
        if (iru_out_ready) begin
          w_capture    = 1'b1;
          w_next_state = STREAM;
        end else begin
          w_next_state = IDLE;
        end
      end
      STREAM: begin
        if (out_ready) begin
          w_xfer = 1'b1;
          if (r_row_idx == LAST_ROW) begin
            w_xfer_last  = 1'b1;
            w_next_state = IDLE;
          end else begin
            w_next_state = STREAM;
          end
        end else begin
          w_next_state = STREAM;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Block buffer and registered row output: row 0 is preloaded at capture so
  // it is valid one cycle later; each transfer loads the following row.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_blk     <= '0;
      r_row     <= '0;
      r_row_idx <= 5'd0;
      r_last    <= 1'b0;
    end else if (w_capture) begin
      r_blk     <= iru_q;
      r_row     <= row_select(iru_q, 5'd0);
      r_row_idx <= 5'd0;
      r_last    <= 1'b0;
    end else if (w_xfer_last) begin
      r_row     <= '0;
      r_row_idx <= 5'd0;
      r_last    <= 1'b0;
    end else if (w_xfer) begin
      r_row     <= row_select(r_blk, r_row_idx + 5'd1);
      r_row_idx <= r_row_idx + 5'd1;
      r_last    <= ((r_row_idx + 5'd1) == LAST_ROW);
    end
  end

  assign rx_ready    = (r_state == IDLE);
  assign out_valid   = (r_state == STREAM);
  assign out_row     = r_row;
  assign out_row_idx = r_row_idx;
  assign out_last    = r_last;

`ifdef IRU_RX_MINMAX_EN
  logic [7:0] w_row_min;
  logic [7:0] w_row_max;
  logic [7:0] r_min;
  logic [7:0] r_max;
  logic       r_stat;

  iru_rx_minmax u_minmax (
    .i_row (r_row),
    .o_min (w_row_min),
    .o_max (w_row_max)
  );

  // Running block statistics: restart at capture, fold each transferred row,
  // and flag completion the cycle after the last row leaves.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_min  <= 8'hFF;
      r_max  <= 8'h00;
      r_stat <= 1'b0;
    end else begin
      r_stat <= w_xfer_last;
      if (w_capture) begin
        r_min <= 8'hFF;
        r_max <= 8'h00;
      end else if (w_xfer) begin
        r_min <= (w_row_min < r_min) ? w_row_min : r_min;
        r_max <= (w_row_max > r_max) ? w_row_max : r_max;
      end
    end
  end

  assign img_min    = r_min;
  assign img_max    = r_max;
  assign stat_valid = r_stat;
`else
  assign img_min    = 8'h00;
  assign img_max    = 8'h00;
  assign stat_valid = 1'b0;
`endif

endmodule

// File: tb/tb_iru_rx.sv
// tb_iru_rx: directed bench for iru_rx with a row scoreboard and a statistics
// scoreboard, both checked by monitors independent of the stimulus.
module tb_iru_rx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic iru_out_ready = 1'b0;
  logic out_ready = 1'b0;
  logic [4:0][79:0][7:0] iru_q = '0;
  logic rx_ready, out_valid, out_last, stat_valid;
  logic [19:0][7:0] out_row;
  logic [4:0] out_row_idx;
  logic [7:0] img_min, img_max;

  typedef struct packed {
    logic [159:0] data;
    logic [4:0]   idx;
    logic         last;
  } exp_row_t;

  typedef struct packed {
    logic [7:0] mn;
    logic [7:0] mx;
  } exp_stat_t;

  exp_row_t  exp_q[$];
  exp_stat_t stat_q[$];
  int total = 0;
  int bad = 0;
  logic [7:0] pix [400];

  iru_rx dut (
    .clk(clk), .rst(rst), .iru_out_ready(iru_out_ready), .iru_q(iru_q),
    .rx_ready(rx_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_row_idx(out_row_idx), .out_last(out_last),
    .img_min(img_min), .img_max(img_max), .stat_valid(stat_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Pack the bench pixel image: pixel p sits at group p/80, offset p%80.
  task automatic load_block(output logic [4:0][79:0][7:0] blk);
    for (int p = 0; p < 400; p++) blk[p / 80][p % 80] = pix[p];
  endtask

  // Queue the 20 expected rows (row r = pixels r*20..r*20+19) and block stats.
  task automatic push_expect(input bit with_stat);
    exp_row_t  e;
    exp_stat_t s;
    s.mn = 8'hFF;
    s.mx = 8'h00;
    for (int r = 0; r < 20; r++) begin
      for (int c = 0; c < 20; c++) e.data[c*8 +: 8] = pix[r*20 + c];
      e.idx  = 5'(r);
      e.last = (r == 19);
      exp_q.push_back(e);
    end
    for (int p = 0; p < 400; p++) begin
      if (pix[p] < s.mn) s.mn = pix[p];
      if (pix[p] > s.mx) s.mx = pix[p];
    end
    if (with_stat) begin
`ifdef IRU_RX_MINMAX_EN
      stat_q.push_back(s);
`endif
    end
  endtask

  // Present the current image with iru_out_ready; keep the request high if asked.
  task automatic send(input bit keep);
    logic [4:0][79:0][7:0] blk;
    load_block(blk);
    push_expect(1'b1);
    iru_q = blk;
    iru_out_ready = 1'b1;
    tick();
    chk("capture_rx_ready", 160'(rx_ready), 160'(1'b0));
    chk("capture_valid", 160'(out_valid), 160'(1'b1));
    iru_out_ready = keep;
  endtask

  task automatic wait_idle(input int bound);
    for (int n = 0; n < bound && !rx_ready; n++) tick();
    chk("wait_idle", 160'(rx_ready), 160'(1'b1));
  endtask

  // Row monitor: every accepted row must match the head of the scoreboard.
  always @(negedge clk) begin : row_mon
    exp_row_t e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_row: got idx %0d expected none", out_row_idx);
      end else begin
        e = exp_q.pop_front();
        chk("row_data", 160'(out_row), e.data);
        chk("row_idx", 160'(out_row_idx), 160'(e.idx));
        chk("row_last", 160'(out_last), 160'(e.last));
      end
    end
  end

  // Statistics monitor: each stat_valid pulse must match a queued block result.
  always @(negedge clk) begin : stat_mon
    exp_stat_t s;
    if (!rst && stat_valid) begin
      if (stat_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_stat: got min %0h max %0h expected no pulse", img_min, img_max);
      end else begin
        s = stat_q.pop_front();
        chk("stat_min", 160'(img_min), 160'(s.mn));
        chk("stat_max", 160'(img_max), 160'(s.mx));
      end
    end
  end

  initial begin
    logic [19:0][7:0] snap;
    int n;
    logic [4:0][79:0][7:0] blk_b;

    // Reset state
    tick(); tick();
    rst = 1'b0;
    chk("rst_rx_ready", 160'(rx_ready), 160'(1'b1));
    chk("rst_valid", 160'(out_valid), 160'(1'b0));
    chk("rst_last", 160'(out_last), 160'(1'b0));
    chk("rst_idx", 160'(out_row_idx), 160'(5'd0));
    chk("rst_row", 160'(out_row), 160'(0));
    chk("rst_stat", 160'(stat_valid), 160'(1'b0));
`ifdef IRU_RX_MINMAX_EN
    chk("rst_min", 160'(img_min), 160'(8'hFF));
`else
    chk("rst_min", 160'(img_min), 160'(8'h00));
`endif
    chk("rst_max", 160'(img_max), 160'(8'h00));

    // T1: ramp image, out_ready high -> 20 rows back to back
    for (int p = 0; p < 400; p++) pix[p] = 8'(p);
    out_ready = 1'b1;
    send(1'b0);
    for (int i = 0; i < 20; i++) begin
      chk("t1_valid", 160'(out_valid), 160'(1'b1));
      if (i == 5) begin
        chk("t1_row5_first", 160'(out_row[0]), 160'(8'd100));
        chk("t1_row5_last", 160'(out_row[19]), 160'(8'd119));
      end
      tick();
    end
    chk("t1_rx_ready_back", 160'(rx_ready), 160'(1'b1));
    chk("t1_valid_low", 160'(out_valid), 160'(1'b0));
    chk("t1_last_low", 160'(out_last), 160'(1'b0));
`ifdef IRU_RX_MINMAX_EN
    chk("t1_stat_pulse", 160'(stat_valid), 160'(1'b1));
`else
    chk("t1_stat_pulse", 160'(stat_valid), 160'(1'b0));
`endif

    // T2: back-pressure at row 7 for 3 cycles
    for (int p = 0; p < 400; p++) pix[p] = 8'(p * 3 + 7);
    send(1'b0);
    for (int k = 0; k < 40 && out_row_idx != 5'd7; k++) tick();
    out_ready = 1'b0;
    snap = out_row;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t2_hold_data", 160'(out_row), 160'(snap));
      chk("t2_hold_idx", 160'(out_row_idx), 160'(5'd7));
      chk("t2_hold_valid", 160'(out_valid), 160'(1'b1));
    end
    out_ready = 1'b1;
    wait_idle(40);

    // T3: iru_out_ready held high, iru_q changed while streaming
    for (int p = 0; p < 400; p++) pix[p] = 8'(255 - p);
    send(1'b1);
    for (int p = 0; p < 400; p++) pix[p] = 8'(p) ^ 8'h5A;
    load_block(blk_b);
    push_expect(1'b1);
    iru_q = blk_b;
    n = 0;
    while (!rx_ready && n < 40) begin
      tick();
      n++;
    end
    chk("t3_period", 160'(n), 160'(20));
    tick();
    iru_out_ready = 1'b0;
    chk("t3_second_capture", 160'(rx_ready), 160'(1'b0));
    wait_idle(40);

    // T4: reset in the middle of a block, then a fresh block from row 0
    for (int p = 0; p < 400; p++) pix[p] = 8'(p + 50);
    send(1'b0);
    for (int k = 0; k < 40 && out_row_idx != 5'd10; k++) tick();
    chk("t4_at_row10", 160'(out_row_idx), 160'(5'd10));
    rst = 1'b1;
    exp_q.delete();
    stat_q.delete();
    tick();
    rst = 1'b0;
    chk("t4_valid", 160'(out_valid), 160'(1'b0));
    chk("t4_rx_ready", 160'(rx_ready), 160'(1'b1));
    chk("t4_stat", 160'(stat_valid), 160'(1'b0));
    chk("t4_idx", 160'(out_row_idx), 160'(5'd0));
    for (int p = 0; p < 400; p++) pix[p] = 8'(p) ^ 8'hA5;
    send(1'b0);
    wait_idle(40);

    // T5: min/max extremes at (13,4) and (0,19)
    for (int p = 0; p < 400; p++) pix[p] = 8'h40;
    pix[13*20 + 4] = 8'h03;
    pix[19] = 8'hF0;
    send(1'b0);
    wait_idle(40);
`ifdef IRU_RX_MINMAX_EN
    chk("t5_stat", 160'(stat_valid), 160'(1'b1));
    chk("t5_min", 160'(img_min), 160'(8'h03));
    chk("t5_max", 160'(img_max), 160'(8'hF0));
`else
    chk("t5_stat", 160'(stat_valid), 160'(1'b0));
    chk("t5_min", 160'(img_min), 160'(8'h00));
    chk("t5_max", 160'(img_max), 160'(8'h00));
`endif
    tick();
    chk("t5_stat_one_cycle", 160'(stat_valid), 160'(1'b0));

    tick(); tick();
    chk("rows_drained", 160'(exp_q.size()), 160'(0));
    chk("stats_drained", 160'(stat_q.size()), 160'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
